// File: rtl/note_judge_multi.sv
// note_judge_multi
//
// N-lane rhythm-game hit judge. Each lane tracks one note at a time, grades
// a key press against the judgement window, and emits one-cycle hit/miss
// pulses. Score, combo and max combo are kept for the display path.
//
// Optional build macro: MISS_ON_EMPTY_PRESS_EN
//   defined   - a press on a tracked note outside the window counts as a MISS
//               and closes the note (penalises key mashing)
//   undefined - such presses are ignored
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   en_i           game active; low forces every lane idle and freezes counters
//   clr_i          synchronous clear of score, combo, max combo and grades
//   note_valid_i   [LANES]        note present per lane
//   note_pos_i     [LANES*POS_W]  lane i position at [i*POS_W +: POS_W]
//   key_press_i    [LANES]        one-cycle press pulse per lane
//   hit_o          [LANES]        one-cycle pulse: lane graded PERFECT/GOOD
//   miss_o         [LANES]        one-cycle pulse: lane graded MISS
//   grade_o        [LANES*2]      last grade: 00 none, 01 GOOD, 10 PERFECT, 11 MISS
//   score_o        [SCORE_W]      accumulated points, saturating
//   combo_o        [COMBO_W]      consecutive hits, saturating
//   max_combo_o    [COMBO_W]      highest combo since clear/reset
//
// Lane FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no note tracked
//   S_ARMED  | note present and not yet judged
//   S_JUDGED | note graded; waiting for note_valid to drop

module note_judge_multi #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned POS_W      = 4,
    parameter int unsigned HIT_POS    = 0,
    parameter int unsigned GOOD_WIN   = 2,
    parameter int unsigned PT_PERFECT = 2,
    parameter int unsigned PT_GOOD    = 1,
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned COMBO_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [LANES-1:0]         note_valid_i,
    input  logic [LANES*POS_W-1:0]   note_pos_i,
    input  logic [LANES-1:0]         key_press_i,
    output logic [LANES-1:0]         hit_o,
    output logic [LANES-1:0]         miss_o,
    output logic [LANES*2-1:0]       grade_o,
    output logic [SCORE_W-1:0]       score_o,
    output logic [COMBO_W-1:0]       combo_o,
    output logic [COMBO_W-1:0]       max_combo_o
);

    localparam int unsigned PW1 = POS_W + 1;
    localparam logic [POS_W:0] HIT_P = PW1'(HIT_POS);

    localparam logic [1:0] G_NONE    = 2'b00;
    localparam logic [1:0] G_GOOD    = 2'b01;
    localparam logic [1:0] G_PERFECT = 2'b10;
    localparam logic [1:0] G_MISS    = 2'b11;

    localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
    localparam logic [31:0] COMBO_MAX = (32'd1 << COMBO_W) - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_JUDGED = 2'd2
    } lane_st_e;

    lane_st_e state_q [LANES];
    lane_st_e state_d [LANES];

    logic [LANES-1:0]       hit_q, hit_d;
    logic [LANES-1:0]       miss_q, miss_d;
    logic [LANES-1:0]       perf_d;
    logic [LANES*2-1:0]     grade_q, grade_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [COMBO_W-1:0]     combo_q, combo_d;
    logic [COMBO_W-1:0]     max_q, max_d;

    logic [LANES-1:0]       in_win;
    logic [LANES-1:0]       on_line;
    logic [LANES-1:0]       elig;

    // Window decode. The extra MSB of the difference flags positions that are
    // already past the judgement line.
    always_comb begin
        logic [POS_W:0] d;
        in_win  = '0;
        on_line = '0;
        d       = '0;
        for (int i = 0; i < LANES; i++) begin
            d = {1'b0, note_pos_i[i*POS_W +: POS_W]} - HIT_P;
            in_win[i]  = !d[POS_W] && (32'(d[POS_W-1:0]) <= GOOD_WIN);
            on_line[i] = !d[POS_W] && (d[POS_W-1:0] == '0);
        end
    end

    // A note appearing in the same cycle as a press is judged immediately,
    // so an idle lane with note_valid high behaves as if already armed.
    always_comb begin
        elig = '0;
        for (int i = 0; i < LANES; i++) begin
            elig[i] = (state_q[i] == S_ARMED) ||
                      ((state_q[i] == S_IDLE) && note_valid_i[i]);
        end
    end

    always_comb begin
        hit_d  = '0;
        miss_d = '0;
        perf_d = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            if (!en_i) begin
                state_d[i] = S_IDLE;
            end else if (elig[i] && key_press_i[i] && in_win[i]) begin
                // A press on the falling cycle of note_valid still wins.
                hit_d[i]   = 1'b1;
                perf_d[i]  = on_line[i];
                state_d[i] = note_valid_i[i] ? S_JUDGED : S_IDLE;
            end else if ((state_q[i] == S_ARMED) && !note_valid_i[i]) begin
                miss_d[i]  = 1'b1;
                state_d[i] = S_IDLE;
`ifdef MISS_ON_EMPTY_PRESS_EN
            end else if (elig[i] && key_press_i[i]) begin
                miss_d[i]  = 1'b1;
                state_d[i] = S_JUDGED;
`endif
            end else if (elig[i]) begin
                state_d[i] = S_ARMED;
            end else if ((state_q[i] == S_JUDGED) && !note_valid_i[i]) begin
                state_d[i] = S_IDLE;
            end
        end
    end

    always_comb begin
        logic [31:0] add;
        logic [31:0] nhit;
        logic [31:0] score_sum;
        logic [31:0] combo_sum;
        add       = '0;
        nhit      = '0;
        grade_d   = grade_q;
        for (int i = 0; i < LANES; i++) begin
            if (hit_d[i]) begin
                add  = add + (perf_d[i] ? PT_PERFECT : PT_GOOD);
                nhit = nhit + 32'd1;
                grade_d[i*2 +: 2] = perf_d[i] ? G_PERFECT : G_GOOD;
            end else if (miss_d[i]) begin
                grade_d[i*2 +: 2] = G_MISS;
            end
        end

        score_sum = 32'(score_q) + add;
        score_d   = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                            : score_sum[SCORE_W-1:0];

        // Any miss breaks the chain; hits in the same cycle are forfeited.
        combo_sum = 32'(combo_q) + nhit;
        if (|miss_d) begin
            combo_d = '0;
        end else begin
            combo_d = (combo_sum > COMBO_MAX) ? COMBO_MAX[COMBO_W-1:0]
                                              : combo_sum[COMBO_W-1:0];
        end
        max_d = (combo_d > max_q) ? combo_d : max_q;

        if (clr_i) begin
            grade_d = {LANES{G_NONE}};
            score_d = '0;
            combo_d = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= S_IDLE;
            end
            hit_q   <= '0;
            miss_q  <= '0;
            grade_q <= '0;
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
            end
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            grade_q <= grade_d;
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign hit_o       = hit_q;
    assign miss_o      = miss_q;
    assign grade_o     = grade_q;
    assign score_o     = score_q;
    assign combo_o     = combo_q;
    assign max_combo_o = max_q;

endmodule

// File: tb/tb_note_judge_multi.sv
module tb_note_judge_multi;

    localparam int HIT   = 0;
    localparam int GWIN  = 2;
    localparam int SMAX  = 16383;
    localparam int CMAX  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  nv  = '0;
    logic [15:0] pos = '0;
    logic [3:0]  kp  = '0;
    logic [3:0]  hit, miss;
    logic [7:0]  grade;
    logic [13:0] score;
    logic [7:0]  combo, max_combo;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    note_judge_multi dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .clr_i       (clr),
        .note_valid_i(nv),
        .note_pos_i  (pos),
        .key_press_i (kp),
        .hit_o       (hit),
        .miss_o      (miss),
        .grade_o     (grade),
        .score_o     (score),
        .combo_o     (combo),
        .max_combo_o (max_combo)
    );

    always #5 clk = ~clk;

    // Behavioural model: per lane, whether a note is "owed" a judgement
    // (0 none, 1 waiting, 2 already judged) plus plain integer counters.
    int       m_ph [4] = '{0, 0, 0, 0};
    int       m_gr [4] = '{0, 0, 0, 0};
    bit [3:0] m_hit  = '0;
    bit [3:0] m_miss = '0;
    int       m_sc   = 0;
    int       m_cb   = 0;
    int       m_mcb  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_ph[i] = 0;
                m_gr[i] = 0;
            end
            m_hit = '0; m_miss = '0;
            m_sc = 0; m_cb = 0; m_mcb = 0;
        end else begin
            bit [3:0] h;
            bit [3:0] m;
            int       pts;
            h = '0; m = '0; pts = 0;
            for (int i = 0; i < 4; i++) begin
                int  p;
                bit  live;
                bit  win;
                p    = int'(pos[i*4 +: 4]);
                live = (m_ph[i] == 1) || (m_ph[i] == 0 && nv[i]);
                win  = (p >= HIT) && (p - HIT <= GWIN);
                if (!en) begin
                    m_ph[i] = 0;
                end else if (live && kp[i] && win) begin
                    h[i]    = 1'b1;
                    pts    += (p == HIT) ? 2 : 1;
                    m_gr[i] = (p == HIT) ? 2 : 1;
                    m_ph[i] = nv[i] ? 2 : 0;
                end else if (m_ph[i] == 1 && !nv[i]) begin
                    m[i]    = 1'b1;
                    m_gr[i] = 3;
                    m_ph[i] = 0;
`ifdef MISS_ON_EMPTY_PRESS_EN
                end else if (live && kp[i]) begin
                    m[i]    = 1'b1;
                    m_gr[i] = 3;
                    m_ph[i] = 2;
`endif
                end else if (live) begin
                    m_ph[i] = 1;
                end else if (m_ph[i] == 2 && !nv[i]) begin
                    m_ph[i] = 0;
                end
            end
            m_sc = (m_sc + pts > SMAX) ? SMAX : m_sc + pts;
            if (m != 0) m_cb = 0;
            else        m_cb = (m_cb + $countones(h) > CMAX) ? CMAX : m_cb + $countones(h);
            if (m_cb > m_mcb) m_mcb = m_cb;
            if (clr) begin
                m_sc = 0; m_cb = 0; m_mcb = 0;
                for (int i = 0; i < 4; i++) m_gr[i] = 0;
            end
            m_hit  = h;
            m_miss = m;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_hit",   32'(hit),       32'(m_hit));
            chk("m_miss",  32'(miss),      32'(m_miss));
            chk("m_grade", 32'(grade),     32'({m_gr[3][1:0], m_gr[2][1:0], m_gr[1][1:0], m_gr[0][1:0]}));
            chk("m_score", 32'(score),     32'(m_sc));
            chk("m_combo", 32'(combo),     32'(m_cb));
            chk("m_max",   32'(max_combo), 32'(m_mcb));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setpos(input int l, input int v);
        pos[l*4 +: 4] = 4'(v);
    endtask

    initial begin
        cyc();
        cmp_on = 1'b1;
        cyc();
        chk("rst_score", 32'(score), 0);
        chk("rst_hit",   32'(hit),   0);
        chk("rst_grade", 32'(grade), 0);
        rst = 1'b0;
        en  = 1'b1;
        cyc();

        // Lane 0 scrolls down, PERFECT at 0
        nv[0] = 1'b1;
        for (int p = 5; p >= 1; p--) begin
            setpos(0, p);
            repeat (4) cyc();
        end
        setpos(0, 0);
        kp[0] = 1'b1;
        cyc();
        kp[0] = 1'b0;
        chk("l0_hit",   32'(hit),        32'h1);
        chk("l0_grade", 32'(grade[1:0]), 2);
        chk("l0_score", 32'(score),      2);
        chk("l0_combo", 32'(combo),      1);
        nv[0] = 1'b0;
        cyc();
        chk("l0_nomiss", 32'(miss), 0);

        // Lane 1 GOOD at pos 2, second press ignored
        nv[1] = 1'b1;
        setpos(1, 2);
        cyc();
        kp[1] = 1'b1;
        cyc();
        kp[1] = 1'b0;
        chk("l1_hit",   32'(hit),        32'h2);
        chk("l1_grade", 32'(grade[3:2]), 1);
        chk("l1_score", 32'(score),      3);
        cyc();
        kp[1] = 1'b1;
        cyc();
        kp[1] = 1'b0;
        chk("l1_repress_hit",   32'(hit),   0);
        chk("l1_repress_score", 32'(score), 3);
        nv[1] = 1'b0;
        cyc();

        // Build combo to 5 with press-on-arrival notes
        setpos(0, 0);
        repeat (3) begin
            nv[0] = 1'b1; kp[0] = 1'b1;
            cyc();
            nv[0] = 1'b0; kp[0] = 1'b0;
            cyc();
        end
        chk("combo5", 32'(combo), 5);
        chk("score9", 32'(score), 9);

        // Lane 2 unjudged note drops out
        nv[2] = 1'b1;
        setpos(2, 7);
        repeat (2) cyc();
        nv[2] = 1'b0;
        cyc();
        chk("l2_miss",  32'(miss),        32'h4);
        chk("l2_combo", 32'(combo),       0);
        chk("l2_max",   32'(max_combo),   5);
        chk("l2_grade", 32'(grade[5:4]),  3);
        cyc();
        chk("l2_single_pulse", 32'(miss), 0);

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_score", 32'(score),     0);
        chk("clr_max",   32'(max_combo), 0);
        chk("clr_grade", 32'(grade),     0);

        // All four lanes PERFECT together
        nv = 4'hF; kp = 4'hF; pos = '0;
        cyc();
        nv = '0; kp = '0;
        chk("all_hit",   32'(hit),       32'hF);
        chk("all_score", 32'(score),     8);
        chk("all_combo", 32'(combo),     4);
        chk("all_max",   32'(max_combo), 4);
        cyc();

        // Combo 3, then lane 0 hit with lane 3 miss in one cycle
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        nv = 4'h7; kp = 4'h7;
        cyc();
        nv = '0; kp = '0;
        cyc();
        chk("c3_combo", 32'(combo), 3);
        nv[3] = 1'b1; setpos(3, 6);
        nv[0] = 1'b1; setpos(0, 0);
        cyc();
        kp[0] = 1'b1; nv[3] = 1'b0;
        cyc();
        kp[0] = 1'b0;
        chk("mix_hit",   32'(hit),       32'h1);
        chk("mix_miss",  32'(miss),      32'h8);
        chk("mix_score", 32'(score),     8);
        chk("mix_combo", 32'(combo),     0);
        chk("mix_max",   32'(max_combo), 3);
        nv[0] = 1'b0;
        cyc();

        // Press outside the window
        nv[1] = 1'b1; setpos(1, 4);
        cyc();
        kp[1] = 1'b1;
        cyc();
        kp[1] = 1'b0;
        chk("out_hit", 32'(hit), 0);
`ifdef MISS_ON_EMPTY_PRESS_EN
        chk("out_miss", 32'(miss), 32'h2);
`else
        chk("out_miss", 32'(miss), 0);
`endif
        nv[1] = 1'b0;
        cyc();
        cyc();

        // en low freezes judging; held note re-arms after en returns
        nv[0] = 1'b1; setpos(0, 0);
        cyc();
        en = 1'b0; kp[0] = 1'b1;
        cyc();
        kp[0] = 1'b0;
        chk("en0_hit", 32'(hit), 0);
        cyc();
        en = 1'b1;
        cyc();
        kp[0] = 1'b1;
        cyc();
        kp[0] = 1'b0;
        chk("en1_hit",   32'(hit),   32'h1);
        chk("en1_score", 32'(score), 10);
        nv[0] = 1'b0;
        cyc();

        // Score and combo saturation
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        pos = '0;
        repeat (2047) begin
            nv = 4'hF; kp = 4'hF;
            cyc();
            nv = '0; kp = '0;
            cyc();
        end
        nv = 4'h7; kp = 4'h7;
        cyc();
        nv = '0; kp = '0;
        cyc();
        chk("sat_pre_score", 32'(score), 16382);
        chk("sat_combo",     32'(combo), 255);
        nv = 4'h1; kp = 4'h1;
        cyc();
        nv = '0; kp = '0;
        chk("sat_score", 32'(score), 16383);
        cyc();
        nv = 4'h1; kp = 4'h1;
        cyc();
        nv = '0; kp = '0;
        chk("sat_hold", 32'(score), 16383);
        cyc();

        // clr beats a same-cycle hit
        clr = 1'b1; nv[0] = 1'b1; kp[0] = 1'b1;
        cyc();
        clr = 1'b0; nv[0] = 1'b0; kp[0] = 1'b0;
        chk("clrhit_score", 32'(score), 0);
        chk("clrhit_combo", 32'(combo), 0);
        chk("clrhit_hit",   32'(hit),   32'h1);
        cyc();

        // Reset mid-note: never graded
        nv[2] = 1'b1; setpos(2, 3);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        nv[2] = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("rst_nomiss", 32'(miss), 0);
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
